// File: rtl/mem_arbiter_pkg.sv
// Shared FSM state and grant encodings for the memory-port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ACC  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way winner select; zero latency.
// No backpressure: o_vld only says some master is eligible this cycle.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic i_c_req,
    input  logic i_d_req,
    input  logic i_d_lock,
    input  gnt_t i_last_grant,
    output logic o_vld,
    output gnt_t o_grant
);

    logic w_c_ok;

    assign w_c_ok = i_c_req && !i_d_lock;

    always_comb begin
        o_vld   = w_c_ok || i_d_req;
        o_grant = GNT_CPU;
        if (w_c_ok && i_d_req) begin
            // On a tie the debug master wins outright, or the master not served last
            o_grant = ((FIXED_PRIO != 0) || (i_last_grant == GNT_CPU)) ? GNT_DBG : GNT_CPU;
        end else if (i_d_req) begin
            o_grant = GNT_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between CPU and debug masters; ack 3 cycles after sampled req.
// Masters hold req until their one-cycle ack; at most one access per 3 cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MEM_ADDR_SIZE = 12,
    parameter int FIXED_PRIO    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_c_req,
    input  logic                     i_c_wen,
    input  logic [MEM_ADDR_SIZE-1:0] i_c_addr,
    input  logic [WIDTH-1:0]         i_c_wdata,
    output logic                     o_c_ack,
    output logic [WIDTH-1:0]         o_c_rdata,
    input  logic                     i_d_req,
    input  logic                     i_d_wen,
    input  logic [MEM_ADDR_SIZE-1:0] i_d_addr,
    input  logic [WIDTH-1:0]         i_d_wdata,
    output logic                     o_d_ack,
    output logic [WIDTH-1:0]         o_d_rdata,
    input  logic                     i_d_lock,
    output logic [MEM_ADDR_SIZE-1:0] o_mem_addr,
    output logic                     o_mem_wen,
    output logic [WIDTH-1:0]         o_mem_wdata,
    input  logic [WIDTH-1:0]         i_mem_rdata,
    output logic                     o_busy
);

    arb_state_t                 r_state;
    arb_state_t                 w_state_nxt;
    gnt_t                       r_grant;
    gnt_t                       r_last_grant;
    gnt_t                       w_pick_grant;
    logic                       w_pick_vld;
    logic [MEM_ADDR_SIZE-1:0]   r_mem_addr;
    logic                       r_mem_wen;
    logic [WIDTH-1:0]           r_mem_wdata;
    logic                       r_c_ack;
    logic                       r_d_ack;
    logic [WIDTH-1:0]           r_c_rdata;
    logic [WIDTH-1:0]           r_d_rdata;

    mem_arbiter_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_c_req      (i_c_req),
        .i_d_req      (i_d_req),
        .i_d_lock     (i_d_lock),
        .i_last_grant (r_last_grant),
        .o_vld        (w_pick_vld),
        .o_grant      (w_pick_grant)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_vld) w_state_nxt = ARB_ACC;
            ARB_ACC:  w_state_nxt = ARB_DONE;
            ARB_DONE: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= ARB_IDLE;
            r_grant      <= GNT_CPU;
            r_last_grant <= GNT_DBG;
            r_mem_addr   <= '0;
            r_mem_wen    <= 1'b0;
            r_mem_wdata  <= '0;
            r_c_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_c_ack <= 1'b0;
            r_d_ack <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant     <= w_pick_grant;
                        r_mem_addr  <= (w_pick_grant == GNT_DBG) ? i_d_addr  : i_c_addr;
                        r_mem_wen   <= (w_pick_grant == GNT_DBG) ? i_d_wen   : i_c_wen;
                        r_mem_wdata <= (w_pick_grant == GNT_DBG) ? i_d_wdata : i_c_wdata;
                    end
                end
                ARB_ACC: begin
                    r_mem_wen <= 1'b0;
                end
                ARB_DONE: begin
                    // Memory data is valid now; ack and data leave registered together
                    r_last_grant <= r_grant;
                    if (r_grant == GNT_DBG) begin
                        r_d_ack   <= 1'b1;
                        r_d_rdata <= i_mem_rdata;
                    end else begin
                        r_c_ack   <= 1'b1;
                        r_c_rdata <= i_mem_rdata;
                    end
                end
                default: r_mem_wen <= 1'b0;
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_wdata = r_mem_wdata;
    assign o_c_ack     = r_c_ack;
    assign o_d_ack     = r_d_ack;
    assign o_c_rdata   = r_c_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_busy      = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin (dut0) and fixed-priority (dut1) instances share stimulus.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        c_req, c_wen, d_req, d_wen, d_lock;
    logic [11:0] c_addr, d_addr;
    logic [31:0] c_wdata, d_wdata;

    logic        c_ack0, d_ack0, mem_wen0, busy0;
    logic [31:0] c_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
    logic [11:0] mem_addr0;
    logic        c_ack1, d_ack1, mem_wen1, busy1;
    logic [31:0] c_rdata1, d_rdata1, mem_wdata1, mem_rdata1;
    logic [11:0] mem_addr1;

    logic [31:0] mem0 [0:4095];
    logic [31:0] mem1 [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.WIDTH(32), .MEM_ADDR_SIZE(12), .FIXED_PRIO(0)) dut0 (
        .i_clk(clk), .i_reset(rst_n),
        .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_ack(c_ack0), .o_c_rdata(c_rdata0),
        .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(d_ack0), .o_d_rdata(d_rdata0), .i_d_lock(d_lock),
        .o_mem_addr(mem_addr0), .o_mem_wen(mem_wen0), .o_mem_wdata(mem_wdata0),
        .i_mem_rdata(mem_rdata0), .o_busy(busy0)
    );

    mem_arbiter #(.WIDTH(32), .MEM_ADDR_SIZE(12), .FIXED_PRIO(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n),
        .i_c_req(c_req), .i_c_wen(c_wen), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_ack(c_ack1), .o_c_rdata(c_rdata1),
        .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(d_ack1), .o_d_rdata(d_rdata1), .i_d_lock(d_lock),
        .o_mem_addr(mem_addr1), .o_mem_wen(mem_wen1), .o_mem_wdata(mem_wdata1),
        .i_mem_rdata(mem_rdata1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories, read-before-write
    always @(posedge clk) begin
        if (mem_wen0) mem0[mem_addr0] <= mem_wdata0;
        mem_rdata0 <= mem0[mem_addr0];
        if (mem_wen1) mem1[mem_addr1] <= mem_wdata1;
        mem_rdata1 <= mem1[mem_addr1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {30'b0, busy1, busy0}, 32'h0);
        chk("rst_acks",  {28'b0, c_ack1, d_ack1, c_ack0, d_ack0}, 32'h0);
        chk("rst_wen",   {30'b0, mem_wen1, mem_wen0}, 32'h0);
        chk("rst_addr",  {8'b0, mem_addr1, mem_addr0}, 32'h0);
        chk("rst_wdata", mem_wdata0 | mem_wdata1, 32'h0);
        chk("rst_rdata", c_rdata0 | d_rdata0 | c_rdata1 | d_rdata1, 32'h0);
        rst_n = 1'b1;
    endtask

    // Single-master transaction; returns ack latency in falling edges for each DUT.
    task automatic run_txn(input logic port, input logic wen, input logic [11:0] addr,
                           input logic [31:0] wdata, output int lat0, output int lat1,
                           output logic [31:0] rd0, output logic [31:0] rd1, output logic other);
        lat0 = 0; lat1 = 0; rd0 = '0; rd1 = '0; other = 1'b0;
        if (port) begin
            d_req = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_wen = wen; c_addr = addr; c_wdata = wdata;
        end
        for (int k = 1; k <= 10 && (lat0 == 0 || lat1 == 0); k++) begin
            @(negedge clk);
            if (port ? (c_ack0 | c_ack1) : (d_ack0 | d_ack1)) other = 1'b1;
            if (lat0 == 0 && (port ? d_ack0 : c_ack0)) begin
                lat0 = k; rd0 = port ? d_rdata0 : c_rdata0;
            end
            if (lat1 == 0 && (port ? d_ack1 : c_ack1)) begin
                lat1 = k; rd1 = port ? d_rdata1 : c_rdata1;
            end
        end
        c_req = 1'b0; d_req = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          lat0, lat1, w;
        logic [31:0] rd0, rd1;
        logic        other, got;
        int          q0 [$];
        int          q1 [$];
        logic        cp, dp, cw, dw;
        logic [11:0] ca, da;
        logic [31:0] cd, dd;
        int          cwait, dwait;
        logic [31:0] refm [8];
        bit          refv [8];

        vecs[0] = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 12'h020, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 12'h020, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 12'h010, 32'h00000000, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 12'h010, 32'h0,        32'h00000000};
        vecs[7] = '{1'b1, 1'b1, 12'hFFF, 32'hA5A5A5A5, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 12'hFFF, 32'h0,        32'hA5A5A5A5};

        c_req = 0; c_wen = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_lock = 0; rst_n = 0;
        @(negedge clk);
        do_reset();

        // Single-master vectors: every transaction acks exactly 3 cycles after req
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].port, vecs[i].wen, vecs[i].addr, vecs[i].wdata, lat0, lat1, rd0, rd1, other);
            chk($sformatf("vec%0d_lat_rr", i), lat0, 3);
            chk($sformatf("vec%0d_lat_fp", i), lat1, 3);
            chk($sformatf("vec%0d_other_ack", i), {31'b0, other}, 32'h0);
            if (!vecs[i].wen) begin
                chk($sformatf("vec%0d_rdata_rr", i), rd0, vecs[i].exp_rd);
                chk($sformatf("vec%0d_rdata_fp", i), rd1, vecs[i].exp_rd);
            end
        end

        // Tie with both requests held: round-robin alternates, fixed priority starves CPU
        do_reset();
        c_req = 1; c_wen = 0; c_addr = 12'h010; d_req = 1; d_wen = 0; d_addr = 12'h020;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (c_ack0) q0.push_back(0);
            if (d_ack0) q0.push_back(1);
            if (c_ack1) q1.push_back(0);
            if (d_ack1) q1.push_back(1);
        end
        chk("rr_ack_count", q0.size(), 4);
        chk("fp_ack_count", q1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_order%0d", i), (i < q0.size()) ? q0[i] : 9, i % 2);
            chk($sformatf("fp_order%0d", i), (i < q1.size()) ? q1[i] : 9, 1);
        end
        d_req = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (c_ack1) got = 1;
        end
        chk("fp_cpu_after_dbg_drop", {31'b0, got}, 32'h1);
        c_req = 0;
        repeat (6) @(negedge clk);

        // Lock holds off the CPU; releasing it grants within 3 cycles
        do_reset();
        d_lock = 1; c_req = 1; c_wen = 0; c_addr = 12'h020;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (c_ack0 | c_ack1 | busy0 | busy1) got = 1;
        end
        chk("lock_no_cpu_grant", {31'b0, got}, 32'h0);
        d_lock = 0;
        lat0 = 0;
        for (int k = 1; k <= 6 && lat0 == 0; k++) begin
            @(negedge clk);
            if (c_ack0 && c_ack1) lat0 = k;
        end
        c_req = 0;
        chk("unlock_lat", lat0, 3);
        chk("unlock_rdata", c_rdata0, 32'h12345678);

        // Lock raised while CPU already in ACC: transaction still completes
        @(negedge clk);
        c_req = 1; c_wen = 0; c_addr = 12'h010;
        @(negedge clk);
        d_lock = 1;
        lat0 = 0;
        for (int k = 2; k <= 8 && lat0 == 0; k++) begin
            @(negedge clk);
            if (c_ack0) lat0 = k;
            if (k == 2) c_req = 0;
        end
        chk("lock_mid_txn_lat", lat0, 3);
        d_lock = 0;
        repeat (3) @(negedge clk);

        // Reset during ACC of a write aborts with no ack
        c_req = 1; c_wen = 1; c_addr = 12'h7FF; c_wdata = 32'h55;
        @(negedge clk);
        chk("abort_in_acc", {30'b0, busy0, mem_wen0}, 32'h3);
        rst_n = 0; c_req = 0;
        @(negedge clk);
        chk("abort_state", {28'b0, busy0, mem_wen0, busy1, mem_wen1}, 32'h0);
        chk("abort_ack", {30'b0, c_ack0, c_ack1}, 32'h0);
        rst_n = 1;
        got = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (c_ack0 | c_ack1 | d_ack0 | d_ack1) got = 1;
        end
        chk("abort_no_late_ack", {31'b0, got}, 32'h0);

        // Back-to-back debug loads then CPU readback
        for (int i = 0; i < 16; i++) begin
            run_txn(1'b1, 1'b1, 12'(i), 32'(i * 3), lat0, lat1, rd0, rd1, other);
            chk($sformatf("load%0d_lat", i), lat0, 3);
        end
        for (int i = 0; i < 16; i++) begin
            run_txn(1'b0, 1'b0, 12'(i), 32'h0, lat0, lat1, rd0, rd1, other);
            chk($sformatf("readback%0d_lat", i), lat0, 3);
            chk($sformatf("readback%0d_rdata", i), rd0, 32'(i * 3));
        end

        // Random two-master traffic against a transaction-ordered memory model (dut0)
        do_reset();
        cp = 0; dp = 0; cwait = 0; dwait = 0;
        cw = 0; dw = 0; ca = '0; da = '0; cd = '0; dd = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (c_ack0 || d_ack0) chk("rand_single_ack", {31'b0, c_ack0 & d_ack0}, 32'h0);
            if (c_ack0) begin
                chk("rand_c_ack_pending", {31'b0, cp}, 32'h1);
                if (cp && cw) begin
                    refm[ca[2:0]] = cd; refv[ca[2:0]] = 1;
                end else if (cp && refv[ca[2:0]]) begin
                    chk("rand_c_rdata", c_rdata0, refm[ca[2:0]]);
                end
                cp = 0; c_req = 0;
            end else if (cp) begin
                cwait++;
                if (cwait == 13) chk("rand_c_wait_bound", cwait, 12);
            end else if ($urandom_range(2) == 0) begin
                cp = 1; cwait = 0; cw = 1'($urandom_range(1));
                ca = 12'h800 + 12'($urandom_range(7)); cd = $urandom;
                c_req = 1; c_wen = cw; c_addr = ca; c_wdata = cd;
            end
            if (d_ack0) begin
                chk("rand_d_ack_pending", {31'b0, dp}, 32'h1);
                if (dp && dw) begin
                    refm[da[2:0]] = dd; refv[da[2:0]] = 1;
                end else if (dp && refv[da[2:0]]) begin
                    chk("rand_d_rdata", d_rdata0, refm[da[2:0]]);
                end
                dp = 0; d_req = 0;
            end else if (dp) begin
                dwait++;
                if (dwait == 13) chk("rand_d_wait_bound", dwait, 12);
            end else if ($urandom_range(2) == 0) begin
                dp = 1; dwait = 0; dw = 1'($urandom_range(1));
                da = 12'h800 + 12'($urandom_range(7)); dd = $urandom;
                d_req = 1; d_wen = dw; d_addr = da; d_wdata = dd;
            end
        end
        w = 0;
        c_req = 0; d_req = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (c_ack0 && !cp) w++;
            if (d_ack0 && !dp) w++;
            if (c_ack0) cp = 0;
            if (d_ack0) dp = 0;
        end
        chk("rand_drain_spurious_ack", w, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
